fetch_stage: RTL

//  Instruction-fetch stage feeding the decode/execute datapath. Owns the PC, issues word

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    // REQ: request on the bus; WAIT: one request outstanding;
    // HOLD: instruction presented to decode; DRAIN: discard a stale response
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - memory, decode and redirect signals of the fetch stage
// Ports (master = fetch stage side):
//   imem_req_valid/ready/addr   word read request to instruction memory
//   imem_rsp_valid/data         in-order read response
//   instr_valid/ready/instr/pc  fetched instruction handed to decode
//   redirect_valid/pc           new PC, flushes in-flight fetch
interface fetch_stage_if #(
    parameter int AW = 32
);
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [AW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, one-outstanding fetch FSM, capture register
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    fetch_stage_if.master: imem request/response, decode handshake, redirect
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                         ADDR_DATA_WIDTH = 32,
    parameter logic [ADDR_DATA_WIDTH-1:0] RESET_VECTOR    = ADDR_DATA_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input logic            clk,
    input logic            reset,
    fetch_stage_if.master  bus
);
    localparam int AW = ADDR_DATA_WIDTH;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic [AW-1:0] redirect_aligned;

    assign redirect_aligned = bus.redirect_pc & ~AW'(INSTR_BYTES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_VECTOR;
            instr_q    <= AW'(NOP_INSTR);
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (bus.redirect_valid) begin
            // Redirect wins over everything. If a request is (or becomes)
            // outstanding without its response having arrived, the response
            // still has to be swallowed in DRAIN before fetching the new PC.
            pc_d = redirect_aligned;
            case (state_q)
                REQ:     state_d = bus.imem_req_ready ? DRAIN : REQ;
                WAIT:    state_d = bus.imem_rsp_valid ? REQ : DRAIN;
                HOLD:    state_d = REQ;
                DRAIN:   state_d = bus.imem_rsp_valid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        // Only edge on which instr/instr_pc change
                        instr_d    = bus.imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + AW'(INSTR_BYTES);
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // All outputs come from registers: no input-to-output combinational path
    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == HOLD);
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;

    a_instr_stable: assert property (@(posedge clk) disable iff (reset)
        bus.instr_valid && !bus.instr_ready |=> $stable(bus.instr) && $stable(bus.instr_pc));

    a_req_aligned: assert property (@(posedge clk) disable iff (reset)
        bus.imem_req_addr[1:0] == 2'b00);

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_rsp_valid && (state_q == REQ || state_q == HOLD)));

endmodule
